// File: rtl/mitch_div_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mitch_div_pipe
// Description : Three-stage pipelined Mitchell log-domain approximate divider.
//               q ~= x / y, unsigned 16-bit operands, unsigned Q16.8 result.
//               A valid/ready handshake lets a sink stall the whole pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module mitch_div_pipe #(
    parameter int W    = 15,  // fraction bits kept after normalization (1..15)
    parameter int FRAC = 8    // fractional bits of the quotient
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] q,
    output logic        dbz
);

    // Keeps the top W bits of the 15-bit normalized fraction.
    localparam logic [14:0] c_FMASK = 15'(15'h7FFF << (15 - W));
    // Mantissa carries 15 fraction bits; the result carries FRAC of them.
    localparam logic [5:0]  c_BIAS  = 6'(15 - FRAC);

    // Position of the most significant set bit (0 for a zero operand).
    function automatic logic [3:0] f_lod(input logic [15:0] v);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) k = i[3:0];
        end
        return k;
    endfunction

    // Stage 1 registers
    logic        r1_valid, r1_zx, r1_zy;
    logic [3:0]  r1_kx, r1_ky;
    logic [14:0] r1_fx, r1_fy;
    // Stage 2 registers
    logic        r2_valid, r2_zx, r2_zy;
    logic [16:0] r2_mant;
    logic [5:0]  r2_e;
    // Stage 3 (output) registers
    logic        r_out_valid, r_dbz;
    logic [23:0] r_q;

    logic        w_stall;
    logic [3:0]  w_kx, w_ky;
    logic [14:0] w_fx, w_fy;
    logic [15:0] w_d;
    logic [16:0] w_mant;
    logic [5:0]  w_e;
    logic [5:0]  w_s, w_nshift;
    logic [23:0] w_qsh, w_q;
    logic        w_dbz;

    // The whole pipe freezes only when a finished result is not being taken.
    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign dbz       = r_dbz;

    // Stage 1: leading-one detection and left-justified, truncated fraction.
    always_comb begin
        w_kx = f_lod(x);
        w_ky = f_lod(y);
        w_fx = 15'(x << (4'd15 - w_kx)) & c_FMASK;
        w_fy = 15'(y << (4'd15 - w_ky)) & c_FMASK;
    end

    // Stage 2: subtract logs; a borrow from the fraction lowers the exponent.
    always_comb begin
        w_d = {1'b0, r1_fx} - {1'b0, r1_fy};
        if (w_d[15]) begin
            w_mant = 17'h10000 + {1'b1, w_d};
        end else begin
            w_mant = 17'h08000 + {1'b0, w_d};
        end
        w_e = {2'b00, r1_kx} - {2'b00, r1_ky} - {5'd0, w_d[15]};
    end

    // Stage 3: antilog by shifting the mantissa into Q16.8, plus zero cases.
    always_comb begin
        w_s      = r2_e - c_BIAS;
        w_nshift = 6'd0 - w_s;
        if (!w_s[5]) begin
            w_qsh = {7'd0, r2_mant} << w_s;
        end else begin
            w_qsh = {7'd0, r2_mant} >> w_nshift;
        end
        w_q   = w_qsh;
        w_dbz = 1'b0;
        if (r2_zy) begin
            w_q   = 24'hFFFFFF;
            w_dbz = 1'b1;
        end else if (r2_zx) begin
            w_q   = 24'd0;
        end
    end

    // Stage 1 register: captures operands whenever the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_zx    <= 1'b0;
            r1_zy    <= 1'b0;
            r1_kx    <= 4'd0;
            r1_ky    <= 4'd0;
            r1_fx    <= 15'd0;
            r1_fy    <= 15'd0;
        end else if (!w_stall) begin
            r1_valid <= in_valid;
            r1_zx    <= (x == 16'd0);
            r1_zy    <= (y == 16'd0);
            r1_kx    <= w_kx;
            r1_ky    <= w_ky;
            r1_fx    <= w_fx;
            r1_fy    <= w_fy;
        end
    end

    // Stage 2 register: log-domain difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_zx    <= 1'b0;
            r2_zy    <= 1'b0;
            r2_mant  <= 17'd0;
            r2_e     <= 6'd0;
        end else if (!w_stall) begin
            r2_valid <= r1_valid;
            r2_zx    <= r1_zx;
            r2_zy    <= r1_zy;
            r2_mant  <= w_mant;
            r2_e     <= w_e;
        end
    end

    // Output register: result held stable until the sink accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q         <= 24'd0;
            r_dbz       <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r2_valid;
            r_q         <= w_q;
            r_dbz       <= w_dbz;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mitch_div_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mitch_div_pipe
// Description : Self-checking bench for mitch_div_pipe (W=15 and W=4 copies
//               sharing one stimulus stream) against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mitch_div_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] x = 16'd0;
    logic [15:0] y = 16'd0;
    logic        in_ready, out_valid, dbz;
    logic [23:0] q;
    logic        in_ready4, out_valid4, dbz4;
    logic [23:0] q4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mitch_div_pipe #(.W(15), .FRAC(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .dbz(dbz)
    );

    mitch_div_pipe #(.W(4), .FRAC(8)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .x(x), .y(y), .out_valid(out_valid4), .out_ready(out_ready),
        .q(q4), .dbz(dbz4)
    );

    // Mitchell quotient from the log definition: log2(v) ~= k + frac,
    // difference split into integer exponent and fraction, then 2^e*(1+m).
    function automatic logic [24:0] model(input int xi, input int yi, input int w);
        int     kx, ky, fx, fy;
        longint l, e, m, val, sh;
        if (yi == 0) return {1'b1, 24'hFFFFFF};
        if (xi == 0) return 25'd0;
        kx = 0;
        while ((xi >> (kx + 1)) != 0) kx++;
        ky = 0;
        while ((yi >> (ky + 1)) != 0) ky++;
        fx = (xi - (1 << kx)) << (15 - kx);
        fy = (yi - (1 << ky)) << (15 - ky);
        fx = (fx >> (15 - w)) << (15 - w);
        fy = (fy >> (15 - w)) << (15 - w);
        l   = longint'(kx - ky) * 32768 + longint'(fx) - longint'(fy);
        e   = l >>> 15;
        m   = l - e * 32768;
        val = 32768 + m;
        sh  = e - 7;
        if (sh >= 0) val = val << sh;
        else         val = val >> (-sh);
        return {1'b0, 24'(val)};
    endfunction

    // Presents one operand pair with out_ready high and waits for the result.
    task automatic do_op(input logic [15:0] xa, input logic [15:0] ya,
                         output logic [23:0] rq, output logic rd,
                         output logic [23:0] rq4, output logic rd4,
                         output int lat);
        out_ready = 1'b1;
        x = xa;
        y = ya;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        rq = q; rd = dbz; rq4 = q4; rd4 = dbz4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, q, dbz, out_valid4, q4, dbz4} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%0b q=%h dbz=%0b required 0/000000/0", out_valid, q, dbz);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b/%0b required 1", in_ready, in_ready4);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [23:0] rq, rq4; logic rd, rd4; int lat;
        do_op(16'd100, 16'd10, rq, rd, rq4, rd4, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 3", lat);
        end
        checks++;
        if (rq !== 24'h000A80 || rd !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_10: got q=%h dbz=%0b required 000a80/0", rq, rd);
        end
        @(negedge clk);
    endtask

    task automatic test_equal_underflow();
        logic [23:0] rq, rq4; logic rd, rd4; int lat;
        logic [24:0] e4;
        do_op(16'h1234, 16'h1234, rq, rd, rq4, rd4, lat);
        e4 = model(32'h1234, 32'h1234, 4);
        checks++;
        if (rq !== 24'h000100 || rd !== 1'b0) begin
            errors++;
            $display("FAIL equal_ops: got q=%h dbz=%0b required 000100/0", rq, rd);
        end
        checks++;
        if ({rd4, rq4} !== e4) begin
            errors++;
            $display("FAIL equal_ops_w4: got q=%h required %h", rq4, e4[23:0]);
        end
        do_op(16'd1, 16'd3, rq, rd, rq4, rd4, lat);
        checks++;
        if (rq !== 24'h000060 || rd !== 1'b0) begin
            errors++;
            $display("FAIL underflow_1_3: got q=%h dbz=%0b required 000060/0", rq, rd);
        end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        logic [23:0] rq, rq4; logic rd, rd4; int lat;
        do_op(16'hFFFF, 16'd1, rq, rd, rq4, rd4, lat);
        checks++;
        if (rq !== 24'hFFFF00 || rd !== 1'b0) begin
            errors++;
            $display("FAIL max_quotient: got q=%h dbz=%0b required ffff00/0", rq, rd);
        end
        do_op(16'd0, 16'd5, rq, rd, rq4, rd4, lat);
        checks++;
        if (rq !== 24'd0 || rd !== 1'b0 || rq4 !== 24'd0 || rd4 !== 1'b0) begin
            errors++;
            $display("FAIL zero_dividend: got q=%h dbz=%0b required 000000/0", rq, rd);
        end
        do_op(16'd7, 16'd0, rq, rd, rq4, rd4, lat);
        checks++;
        if (rq !== 24'hFFFFFF || rd !== 1'b1 || rq4 !== 24'hFFFFFF || rd4 !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero: got q=%h dbz=%0b required ffffff/1", rq, rd);
        end
        @(negedge clk);
    endtask

    task automatic test_trunc();
        logic [23:0] rq, rq4; logic rd, rd4; int lat;
        do_op(16'd100, 16'd10, rq, rd, rq4, rd4, lat);
        checks++;
        if (rq4 !== 24'h000A80) begin
            errors++;
            $display("FAIL trunc_100_10: got q=%h required 000a80", rq4);
        end
        do_op(16'h00FF, 16'd1, rq, rd, rq4, rd4, lat);
        checks++;
        if (rq4 !== 24'h00F800) begin
            errors++;
            $display("FAIL trunc_ff_1_w4: got q=%h required 00f800", rq4);
        end
        checks++;
        if (rq !== 24'h00FF00) begin
            errors++;
            $display("FAIL trunc_ff_1_w15: got q=%h required 00ff00", rq);
        end
        @(negedge clk);
    endtask

    // Streams n back-to-back pairs; out_ready follows 1,0,0,... or is random.
    task automatic test_stream(input int n, input bit rand_mode);
        logic [15:0] xs[$], ys[$];
        logic [24:0] e15, e4;
        logic [23:0] held_q;
        logic        held;
        int sent, got, cyc;
        for (int i = 0; i < n; i++) begin
            xs.push_back(($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            ys.push_back(($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
        end
        sent = 0; got = 0; cyc = 0; held = 1'b0; held_q = 24'd0;
        while (got < n && cyc < 2000) begin
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ((cyc % 3) == 0);
            if (sent < n) begin
                in_valid = 1'b1; x = xs[sent]; y = ys[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || q !== held_q) begin
                    errors++;
                    $display("FAIL stall_hold: got ov=%0b q=%h required 1/%h", out_valid, q, held_q);
                end
            end
            checks++;
            if (in_ready !== !(out_valid && !out_ready) || in_ready4 !== in_ready) begin
                errors++;
                $display("FAIL in_ready: got %0b required %0b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got >= sent) begin
                    errors++;
                    $display("FAIL stream_extra: got result %0d with only %0d sent", got, sent);
                end else begin
                    e15 = model(int'(xs[got]), int'(ys[got]), 15);
                    e4  = model(int'(xs[got]), int'(ys[got]), 4);
                    if ({dbz, q} !== e15 || {dbz4, q4} !== e4 || out_valid4 !== 1'b1) begin
                        errors++;
                        $display("FAIL stream_result[%0d] x=%h y=%h: got %0b/%h w4 %0b/%h required %0b/%h w4 %0b/%h",
                                 got, xs[got], ys[got], dbz, q, dbz4, q4, e15[24], e15[23:0], e4[24], e4[23:0]);
                    end
                end
                got++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_q = q;
            end else begin
                held = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL stream_timeout: got %0d results required %0d", got, n);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_duplicate: got out_valid=%0b required 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 16'(200 + i * 37);
            y = 16'(3 + i);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: got out_valid=%0b required 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || q !== 24'd0 || dbz !== 1'b0 || out_valid4 !== 1'b0 || q4 !== 24'd0) begin
            errors++;
            $display("FAIL midflight_async: got ov=%0b q=%h dbz=%0b required 0/000000/0", out_valid, q, dbz);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin
                errors++;
                $display("FAIL midflight_stale: got out_valid=%0b required 0", out_valid);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_equal_underflow();
        test_extremes();
        test_trunc();
        test_stream(6, 1'b0);
        test_stream(60, 1'b1);
        test_reset_midflight();
        test_stream(10, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mitch_div_pipe.md
Name: mitch_div_pipe

Overview:
- Pipelined Mitchell log-domain approximate divider. It is the inverse companion of the team's approximate log multipliers.
- Computes q ≈ x / y for 16-bit unsigned operands.
- Output is an unsigned Q16.8 fixed-point quotient.
- Sits behind the same register-wrapped test top as the multipliers, but adds a valid/ready handshake so it can be driven by stream sources and stalled by sinks.

Parameters:
- W, 15, fraction bits kept after leading-one normalization (1..15); lower bits are zeroed (truncation, as in the TRUNC multipliers).
- FRAC, 8, fractional bits of the output quotient; fixed at 8 for this revision.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- x  input  16  dividend, unsigned
- y  input  16  divisor, unsigned
- out_valid  output  1  q/dbz valid
- out_ready  input  1  sink accepts result
- q  output  24  quotient, unsigned Q16.8
- dbz  output  1  divide-by-zero flag, qualified by out_valid

Behaviour:
- Reset (async, active-high): all stage valid bits, q, dbz and out_valid go to 0 immediately. In-flight operations are discarded. in_ready reads 1 once rst deasserts.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every stage register holds its value and x/y are ignored.
  - When not stalled, all stages advance and bubbles (valid=0) propagate.
  - Throughput is 1 result per cycle with out_ready held high.
- Latency: 3 cycles from input transfer to out_valid, with no stall.
- Stage 1 (LOD/normalize):
  - kx = index of leading one of x, ky = same for y (4 bits each).
  - fx = (x << (15-kx))[14:0] with bits below 15-W forced to 0; fy likewise.
  - Register zx = (x==0), zy = (y==0).
- Stage 2 (log subtract):
  - d = fx - fy (signed, 16 bits).
  - If d >= 0: mant = 2^15 + d, e = kx - ky.
  - Else: mant = 2^16 + d, e = kx - ky - 1.
  - e is signed 6-bit, range -16..15; mant is 17 bits.
- Stage 3 (antilog):
  - s = e - 7. If s >= 0, q = mant << s; else q = mant >> (-s), discarding shifted-out bits (truncate, no rounding).
  - Result always fits 24 bits (max 0xFFFF00).
  - zy: q = 0xFFFFFF, dbz = 1.
  - zx && !zy: q = 0, dbz = 0.
  - Otherwise dbz = 0.
- out_valid rises at the end of stage 3 and stays high, with q/dbz stable, until accepted.
- Simultaneous output accept and new input in the same cycle is legal and does not insert a bubble.
- No exactness guarantee: the error bound is Mitchell's (quotient up to ~12.5% high/low). Powers of two divide exactly.

Test Plan:
- Basic, W=15, out_ready=1: x=100, y=10 -> q=0x000A80 (10.5), dbz=0, out_valid exactly 3 cycles after the accept.
- Equal operands and underflow: x=y=0x1234 -> q=0x000100; x=1, y=3 -> q=0x000060 (0.375; d<0 path).
- Extremes: x=0xFFFF, y=1 -> q=0xFFFF00; x=0, y=5 -> q=0, dbz=0; x=7, y=0 -> q=0xFFFFFF, dbz=1.
- Backpressure:
  - Stream 6 back-to-back pairs while out_ready toggles 1,0,0,1,...
  - Required: no loss or duplication, in-order results matching a reference model, q stable while out_valid && !out_ready, in_ready=0 exactly during stall.
- Reset mid-flight: assert rst asynchronously with 3 ops in flight -> out_valid/q/dbz drop to 0 immediately; no stale result appears after release.
- Truncation, W=4: x=100, y=10 -> q=0x000A80 (fractions representable in 4 bits); x=0x00FF, y=1 -> fx truncated to 0.9375, q=0x00F800.
